// File: rtl/noise_cfg_spi_master_pkg.sv
// Shared definitions for the noise-channel config link (master and noise_gen receiver).
package noise_spi_pkg;

  localparam int unsigned FRAME_BITS = 40;
  localparam int unsigned FREQ_W     = 17;
  localparam int unsigned LFSR_W     = 23;
  localparam int unsigned FREQ_MSB   = 39;
  localparam int unsigned FREQ_LSB   = 23;

  typedef struct packed {
    logic [FREQ_W-1:0] freq_div;
    logic [LFSR_W-1:0] lfsr;
  } noise_frame_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_GAP   = 3'd4
  } spi_state_e;

endpackage

// File: rtl/noise_cfg_spi_master_if.sv
// Request handshake plus SPI pins of the noise config master.
interface noise_cfg_spi_master_if;
  import noise_spi_pkg::*;

  logic              tx_valid;
  logic              tx_ready;
  logic [FREQ_W-1:0] tx_freq_div;
  logic [LFSR_W-1:0] tx_lfsr;
  logic              spi_clock;
  logic              spi_data;
  logic              spi_cs;
  logic              busy;
  logic              done;

  // Requester side (sequencer / self-test logic)
  modport master (
    output tx_valid, tx_freq_div, tx_lfsr,
    input  tx_ready, spi_clock, spi_data, spi_cs, busy, done
  );

  // The SPI master block itself
  modport slave (
    input  tx_valid, tx_freq_div, tx_lfsr,
    output tx_ready, spi_clock, spi_data, spi_cs, busy, done
  );

endinterface

// File: rtl/noise_cfg_spi_master_halfbit_timer.sv
// Free-running half-bit timer: 1-cycle tick every CLK_DIV cycles while running.
module spi_halfbit_timer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic i_clear,
  input  logic i_run,
  output logic o_tick_c
);

  localparam int unsigned      CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign o_tick_c = i_run && (r_cnt == LAST);

endmodule

// File: rtl/noise_cfg_spi_master.sv
// SPI mode-0 master serialising one 40-bit {freq_div, lfsr_seed} noise config frame per request.
module noise_cfg_spi_master
  import noise_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 8
) (
  input logic                    sys_clk,
  input logic                    sys_rst_n,
  noise_cfg_spi_master_if.slave  bus
);

  localparam int unsigned      BIT_W    = 6;
  localparam int unsigned      GAP_W    = $clog2(CS_GAP + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(CS_GAP);

  // Receiver synchronisers need at least 3 sys_clk per SCK level and a real CS-high gap
  if (CLK_DIV < 4) begin : g_bad_clk_div
    $error("noise_cfg_spi_master: CLK_DIV must be >= 4");
  end
  if (CS_GAP < 4) begin : g_bad_cs_gap
    $error("noise_cfg_spi_master: CS_GAP must be >= 4");
  end

  spi_state_e            r_state, w_state;
  logic [FRAME_BITS-1:0] r_shift, w_shift;
  logic [BIT_W-1:0]      r_bit_cnt, w_bit_cnt;
  logic                  r_last, w_last;
  logic [GAP_W-1:0]      r_gap_cnt, w_gap_cnt;
  logic                  r_sck, w_sck;
  logic                  r_cs, w_cs;
  logic                  r_ready, w_ready;
  logic                  r_busy, w_busy;
  logic                  r_done, w_done;
  logic                  w_clear;
  logic                  w_run;
  logic                  w_tick;
  noise_frame_t          w_frame;

  assign w_frame.freq_div = bus.tx_freq_div;
  assign w_frame.lfsr     = bus.tx_lfsr;

  assign w_run = (r_state == S_SETUP) || (r_state == S_HI) || (r_state == S_LO);

  spi_halfbit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i_clear   (w_clear),
    .i_run     (w_run),
    .o_tick_c  (w_tick)
  );

  // State and output registers; async reset drops CS/SCK immediately mid-frame
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_last    <= 1'b0;
      r_gap_cnt <= '0;
      r_sck     <= 1'b0;
      r_cs      <= 1'b1;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_shift   <= w_shift;
      r_bit_cnt <= w_bit_cnt;
      r_last    <= w_last;
      r_gap_cnt <= w_gap_cnt;
      r_sck     <= w_sck;
      r_cs      <= w_cs;
      r_ready   <= w_ready;
      r_busy    <= w_busy;
      r_done    <= w_done;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state   = r_state;
    w_shift   = r_shift;
    w_bit_cnt = r_bit_cnt;
    w_last    = r_last;
    w_gap_cnt = r_gap_cnt;
    w_sck     = r_sck;
    w_cs      = r_cs;
    w_ready   = r_ready;
    w_busy    = r_busy;
    w_done    = 1'b0;
    w_clear   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.tx_valid && r_ready) begin
          w_clear   = 1'b1;
          w_shift   = w_frame;
          w_bit_cnt = '0;
          w_last    = 1'b0;
          w_cs      = 1'b0;
          w_ready   = 1'b0;
          w_busy    = 1'b1;
          w_state   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_tick) begin
          w_sck   = 1'b1;
          w_state = S_HI;
        end
      end
      S_HI: begin
        if (w_tick) begin
          w_sck   = 1'b0;
          w_state = S_LO;
          // MOSI is the shifter MSB, so it only moves on the SCK falling edge
          if (r_bit_cnt < LAST_BIT) begin
            w_shift   = {r_shift[FRAME_BITS-2:0], 1'b0};
            w_bit_cnt = r_bit_cnt + BIT_W'(1);
          end else begin
            w_last = 1'b1;
          end
        end
      end
      S_LO: begin
        if (w_tick) begin
          if (!r_last) begin
            w_sck   = 1'b1;
            w_state = S_HI;
          end else begin
            w_cs      = 1'b1;
            w_shift   = '0;
            w_done    = 1'b1;
            w_gap_cnt = '0;
            w_state   = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_END) begin
          w_ready = 1'b1;
          w_busy  = 1'b0;
          w_state = S_IDLE;
        end else begin
          w_gap_cnt = r_gap_cnt + GAP_W'(1);
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign bus.tx_ready  = r_ready;
  assign bus.spi_clock = r_sck;
  assign bus.spi_data  = r_shift[FRAME_BITS-1];
  assign bus.spi_cs    = r_cs;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_noise_cfg_spi_master.sv
// Self-checking bench: table + random frames into a behavioural SPI receiver model.
module tb_noise_cfg_spi_master;
  import noise_spi_pkg::*;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned CS_GAP  = 8;
  localparam int unsigned CS_LOW  = 81 * CLK_DIV;
  localparam int unsigned LAT     = 81 * CLK_DIV + CS_GAP + 1;
  localparam int          BOUND   = 2000;

  logic sys_clk;
  logic sys_rst_n;

  noise_cfg_spi_master_if bus();

  noise_cfg_spi_master #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;

  // Receiver model: shifts MOSI on SCK rise, keeps a frame only if exactly 40 bits arrived
  logic [39:0] rx_sh      = '0;
  int          rx_bits    = 0;
  logic [16:0] rx_freq    = '0;
  logic [22:0] rx_lfsr    = '0;
  int          rx_frames  = 0;
  int          last_bits  = 0;
  int          last_cs_low  = 0;
  int          last_cs_high = 0;
  int          run        = 0;
  int          done_cnt   = 0;
  int          mosi_glitch = 0;
  logic        prev_sck   = 1'b0;
  logic        prev_cs    = 1'b1;
  logic        prev_mosi  = 1'b0;

  always @(negedge sys_clk) begin
    if (bus.done) done_cnt++;
    if (prev_sck && bus.spi_clock && (bus.spi_data != prev_mosi)) mosi_glitch++;
    if (!bus.spi_cs && bus.spi_clock && !prev_sck) begin
      rx_sh = {rx_sh[38:0], bus.spi_data};
      rx_bits++;
    end
    if (bus.spi_cs != prev_cs) begin
      if (bus.spi_cs) begin
        last_cs_low = run;
        last_bits   = rx_bits;
        if (rx_bits == 40) begin
          rx_freq = rx_sh[FREQ_MSB:FREQ_LSB];
          rx_lfsr = rx_sh[FREQ_LSB-1:0];
          rx_frames++;
        end
      end else begin
        last_cs_high = run;
      end
      run = 1;
    end else begin
      run++;
    end
    if (bus.spi_cs) rx_bits = 0;
    prev_sck  = bus.spi_clock;
    prev_cs   = bus.spi_cs;
    prev_mosi = bus.spi_data;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame on the wire is freq_div weighted by 2^23 plus the seed
  function automatic logic [39:0] frame_of(input logic [16:0] f, input logic [22:0] l);
    return (40'(f) << LFSR_W) + 40'(l);
  endfunction

  // mode 0: drop valid after accept; 1: scramble inputs each cycle; 2: hold valid high
  task automatic run_frame(input logic [16:0] f, input logic [22:0] l, input logic [39:0] exp,
                           input int mode, input string name);
    int n;
    int fr0;
    int dn0;
    n = 0;
    while (bus.tx_ready !== 1'b1 && n < BOUND) begin
      @(posedge sys_clk); #1; n++;
    end
    chk({name, " ready_wait"}, 64'(n < BOUND), 64'd1);
    bus.tx_freq_div = f;
    bus.tx_lfsr     = l;
    bus.tx_valid    = 1'b1;
    fr0 = rx_frames;
    dn0 = done_cnt;
    @(posedge sys_clk); #1;
    chk({name, " accept"}, {bus.tx_ready, bus.busy, bus.spi_cs, bus.spi_clock, bus.spi_data},
        {1'b0, 1'b1, 1'b0, 1'b0, exp[39]});
    if (mode != 2) bus.tx_valid = 1'b0;
    n = 0;
    while (bus.tx_ready !== 1'b1 && n < BOUND) begin
      if (mode == 1) begin
        bus.tx_freq_div = 17'($urandom);
        bus.tx_lfsr     = 23'($urandom);
      end
      @(posedge sys_clk); #1; n++;
    end
    chk({name, " latency"}, 64'(n), 64'(LAT));
    chk({name, " frames"}, 64'(rx_frames - fr0), 64'd1);
    chk({name, " rx_data"}, 64'({rx_freq, rx_lfsr}), 64'(exp));
    chk({name, " cs_low"}, 64'(last_cs_low), 64'(CS_LOW));
    chk({name, " sck_rises"}, 64'(last_bits), 64'd40);
    chk({name, " done"}, 64'(done_cnt - dn0), 64'd1);
    chk({name, " busy_end"}, 64'(bus.busy), 64'd0);
  endtask

  typedef struct {
    logic [16:0] f;
    logic [22:0] l;
    logic [39:0] exp;
    int          mode;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [16:0] fa, fb, fr;
    logic [22:0] la, lb, lr;
    int          fr0, dn0;
    int          n;
    logic [16:0] sv_freq;
    logic [22:0] sv_lfsr;

    tbl[0] = '{17'd13000,   23'd111,      40'h196400006F, 0};
    tbl[1] = '{17'h1FFFF,   23'h7FFFFF,   40'hFFFFFFFFFF, 0};
    tbl[2] = '{17'h00001,   23'h000001,   40'h0000800001, 0};
    tbl[3] = '{17'h00000,   23'h000000,   40'h0000000000, 1};
    tbl[4] = '{17'h0AAAA,   23'h555555,   40'h5555555555, 1};
    tbl[5] = '{17'h10000,   23'h000000,   40'h8000000000, 0};

    bus.tx_valid    = 1'b0;
    bus.tx_freq_div = '0;
    bus.tx_lfsr     = '0;
    sys_rst_n       = 1'b1;
    #2 sys_rst_n    = 1'b0;
    #1;
    chk("reset_out", {bus.spi_cs, bus.spi_clock, bus.spi_data, bus.tx_ready, bus.busy, bus.done},
        6'b100100);
    repeat (4) @(posedge sys_clk);
    @(negedge sys_clk) sys_rst_n = 1'b1;

    // Idle outputs stay quiet with no request
    for (int i = 0; i < 100; i++) begin
      @(posedge sys_clk); #1;
      chk("idle_out", {bus.spi_cs, bus.spi_clock, bus.spi_data, bus.tx_ready, bus.busy, bus.done},
          6'b100100);
    end

    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i].f, tbl[i].l, tbl[i].exp, tbl[i].mode, $sformatf("tbl%0d", i));
    end

    // Back-to-back with tx_valid held high across the gap
    fa = 17'd12345; la = 23'h0ABCDE;
    fb = 17'h1F00F; lb = 23'h700007;
    run_frame(fa, la, frame_of(fa, la), 2, "b2b_a");
    run_frame(fb, lb, frame_of(fb, lb), 0, "b2b_b");
    chk("b2b cs_high_gap", 64'(last_cs_high), 64'(CS_GAP + 2));

    for (int i = 0; i < 8; i++) begin
      fr = 17'($urandom);
      lr = 23'($urandom);
      run_frame(fr, lr, frame_of(fr, lr), int'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    // Reset after the 20th SCK rise: frame must be dropped, no done
    n = 0;
    while (bus.tx_ready !== 1'b1 && n < BOUND) begin @(posedge sys_clk); #1; n++; end
    bus.tx_freq_div = 17'h01234;
    bus.tx_lfsr     = 23'h0F0F0F;
    bus.tx_valid    = 1'b1;
    @(posedge sys_clk); #1;
    bus.tx_valid = 1'b0;
    n = 0;
    while (rx_bits < 20 && n < BOUND) begin @(posedge sys_clk); #1; n++; end
    chk("rst_mid reach20", 64'(rx_bits), 64'd20);
    sv_freq = rx_freq;
    sv_lfsr = rx_lfsr;
    fr0 = rx_frames;
    dn0 = done_cnt;
    sys_rst_n = 1'b0;
    #1;
    chk("rst_mid async_out", {bus.spi_cs, bus.spi_clock, bus.tx_ready, bus.busy}, 4'b1010);
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk) sys_rst_n = 1'b1;
    repeat (20) @(posedge sys_clk);
    #1;
    chk("rst_mid frames", 64'(rx_frames - fr0), 64'd0);
    chk("rst_mid rx_regs", 64'({rx_freq, rx_lfsr}), 64'({sv_freq, sv_lfsr}));
    chk("rst_mid no_done", 64'(done_cnt - dn0), 64'd0);
    chk("rst_mid ready", {bus.tx_ready, bus.busy, bus.spi_cs}, 3'b101);

    run_frame(17'h0F0F0, 23'h123456, frame_of(17'h0F0F0, 23'h123456), 0, "post_rst");

    chk("mosi_stable_while_sck_high", 64'(mosi_glitch), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
